// File: rtl/ad9708_dac_driver.sv
// ad9708_dac_driver
// Streams samples from the DSP fabric to a parallel high-speed DAC
// (AD9708/AD9764 class). Samples arrive on a valid/ready interface, are
// buffered in a small FIFO and played out at master_clock/2. The DAC clock
// and data pins are both driven from registers. Data changes on the same
// edge that drives dac_clk low, so it is stable for one full master_clock
// period before and after each rising dac_clk edge.
//
// Ports:
//   master_clock    system clock, rising edge
//   reset           asynchronous, active-low reset
//   enable          playback enable
//   twos_comp       1: s_data is two's complement (MSB inverted on output)
//   s_data/s_valid  input sample stream
//   s_ready         registered; high when a sample can be accepted
//   dac_data        registered sample to the DAC pins
//   dac_clk         registered DAC clock (DAC latches on its rising edge)
//   underflow       one-cycle pulse per underflow event
//   underflow_count saturating count of underflow events
//   fifo_level      current FIFO occupancy
module ad9708_dac_driver #(
  parameter int unsigned DATA_WIDTH  = 12,
  parameter int unsigned FIFO_DEPTH  = 8,
  parameter int unsigned PRIME_LEVEL = 4
) (
  input  logic                          master_clock,
  input  logic                          reset,
  input  logic                          enable,
  input  logic                          twos_comp,
  input  logic [DATA_WIDTH-1:0]         s_data,
  input  logic                          s_valid,
  output logic                          s_ready,
  output logic [DATA_WIDTH-1:0]         dac_data,
  output logic                          dac_clk,
  output logic                          underflow,
  output logic [15:0]                   underflow_count,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned LW = AW + 1;
  localparam logic [DATA_WIDTH-1:0] MIDSCALE = {1'b1, {(DATA_WIDTH-1){1'b0}}};
  localparam logic [DATA_WIDTH-1:0] MSB_MASK = {1'b1, {(DATA_WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE,
    PRIME,
    RUN
  } state_e;

  state_e                state_q;
  logic                  phase_q;
  logic [DATA_WIDTH-1:0] data_q;
  logic                  uf_q;
  logic [15:0]           ucnt_q;

  logic                  ready_q;
  logic                  ready_d;
  logic [AW-1:0]         wr_ptr_q;
  logic [AW-1:0]         rd_ptr_q;
  logic [LW-1:0]         level_q;
  logic [LW-1:0]         level_d;
  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];

  logic                  slot;
  logic                  push;
  logic                  pop;
  logic                  uf_event;
  logic [DATA_WIDTH-1:0] pop_data;

  // An update slot is the edge on which dac_clk falls.
  assign slot = (state_q != IDLE) && phase_q;
  assign push = s_valid && ready_q;

  // PRIME pops in the same slot that it moves to RUN.
  assign pop = slot && enable && (level_q != '0) &&
               ((state_q == RUN) ||
                ((state_q == PRIME) && (level_q >= LW'(PRIME_LEVEL))));

  assign uf_event = slot && enable && (state_q == RUN) && (level_q == '0);

  assign pop_data = twos_comp ? (mem[rd_ptr_q] ^ MSB_MASK) : mem[rd_ptr_q];

  always_comb begin
    level_d = level_q;
    if (push && !pop) begin
      level_d = level_q + 1'b1;
    end else if (!push && pop) begin
      level_d = level_q - 1'b1;
    end
  end

  // s_ready is a registered look-ahead: a full FIFO refuses a push even if a
  // pop happens in the same cycle, so it can never be overwritten.
  assign ready_d = (level_d < LW'(FIFO_DEPTH));

  always_ff @(posedge master_clock or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      ready_q  <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      level_q <= level_d;
      ready_q <= ready_d;
    end
  end

  always_ff @(posedge master_clock) begin
    if (push) begin
      mem[wr_ptr_q] <= s_data;
    end
  end

  always_ff @(posedge master_clock or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      phase_q <= 1'b0;
      data_q  <= MIDSCALE;
      uf_q    <= 1'b0;
      ucnt_q  <= '0;
    end else begin
      uf_q <= uf_event;
      if (uf_event && (ucnt_q != '1)) begin
        ucnt_q <= ucnt_q + 1'b1;
      end
      case (state_q)
        IDLE: begin
          phase_q <= 1'b0;
          data_q  <= MIDSCALE;
          if (enable) begin
            state_q <= PRIME;
            phase_q <= 1'b1;
          end
        end
        PRIME, RUN: begin
          phase_q <= ~phase_q;
          // Leaving only on a slot means dac_clk has just completed its
          // high phase, so stopping never produces a runt pulse.
          if (slot) begin
            if (!enable) begin
              state_q <= IDLE;
              data_q  <= MIDSCALE;
            end else if (pop) begin
              state_q <= RUN;
              data_q  <= pop_data;
            end
          end
        end
        default: begin
          state_q <= IDLE;
          phase_q <= 1'b0;
          data_q  <= MIDSCALE;
        end
      endcase
    end
  end

  assign s_ready         = ready_q;
  assign dac_data        = data_q;
  assign dac_clk         = phase_q;
  assign underflow       = uf_q;
  assign underflow_count = ucnt_q;
  assign fifo_level      = level_q;

endmodule

// File: tb/tb_ad9708_dac_driver.sv
// Self-checking bench for ad9708_dac_driver. A behavioural model (sample
// queue plus play/clock flags) predicts every output each cycle; directed
// scenarios add hand-computed literal expectations.
module tb_ad9708_dac_driver;

  localparam int DW    = 12;
  localparam int DEPTH = 8;
  localparam int PRIME = 4;
  localparam logic [DW-1:0] MID = 12'h800;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          enable = 1'b0;
  logic          twos_comp = 1'b0;
  logic [DW-1:0] s_data = '0;
  logic          s_valid = 1'b0;
  logic          s_ready;
  logic [DW-1:0] dac_data;
  logic          dac_clk;
  logic          underflow;
  logic [15:0]   underflow_count;
  logic [3:0]    fifo_level;

  ad9708_dac_driver #(
    .DATA_WIDTH (DW),
    .FIFO_DEPTH (DEPTH),
    .PRIME_LEVEL(PRIME)
  ) dut (
    .master_clock   (clk),
    .reset          (reset),
    .enable         (enable),
    .twos_comp      (twos_comp),
    .s_data         (s_data),
    .s_valid        (s_valid),
    .s_ready        (s_ready),
    .dac_data       (dac_data),
    .dac_clk        (dac_clk),
    .underflow      (underflow),
    .underflow_count(underflow_count),
    .fifo_level     (fifo_level)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  logic [DW-1:0] q[$];
  logic          m_clk = 1'b0;
  logic [DW-1:0] m_data = MID;
  logic          m_ready = 1'b0;
  logic          m_uf = 1'b0;
  int            m_uevents = 0;
  bit            m_active = 1'b0;
  bit            m_playing = 1'b0;
  bit            mp_push;
  bit            mp_slot;
  logic [DW-1:0] mp_din;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      q.delete();
      m_clk = 1'b0; m_data = MID; m_ready = 1'b0; m_uf = 1'b0;
      m_uevents = 0; m_active = 1'b0; m_playing = 1'b0;
    end else begin
      mp_push = s_valid && m_ready;
      mp_din  = s_data;
      mp_slot = m_active && m_clk;
      m_uf    = 1'b0;
      if (!m_active) begin
        if (enable) begin
          m_active = 1'b1;
          m_clk    = 1'b1;
        end
      end else begin
        m_clk = ~m_clk;
        if (mp_slot) begin
          if (!enable) begin
            m_active = 1'b0; m_playing = 1'b0; m_data = MID;
          end else begin
            if (!m_playing && q.size() >= PRIME) m_playing = 1'b1;
            if (m_playing) begin
              if (q.size() > 0) begin
                m_data = q.pop_front();
                if (twos_comp) m_data[DW-1] = ~m_data[DW-1];
              end else begin
                m_uf = 1'b1;
                m_uevents++;
              end
            end
          end
        end
      end
      if (mp_push) q.push_back(mp_din);
      m_ready = (q.size() < DEPTH);
    end
  end

  // ---------------- checking ----------------
  int            checks = 0;
  int            errors = 0;
  int            ucnt_base = 0;
  int            uev_mark = 0;
  logic [DW-1:0] seen[$];
  logic          prev_clk = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic timeout_fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s: timed out at %0t", name, $time);
  endtask

  task automatic compare_model();
    int e;
    e = ucnt_base + (m_uevents - uev_mark);
    if (e > 65535) e = 65535;
    chk("dac_clk", {31'd0, dac_clk}, {31'd0, m_clk});
    chk("dac_data", {20'd0, dac_data}, {20'd0, m_data});
    chk("s_ready", {31'd0, s_ready}, {31'd0, m_ready});
    chk("underflow", {31'd0, underflow}, {31'd0, m_uf});
    chk("fifo_level", {28'd0, fifo_level}, q.size());
    chk("underflow_count", {16'd0, underflow_count}, e);
  endtask

  // Each step compares on the falling edge and returns 1 unit after the
  // next rising edge, where the stimulus is changed.
  task automatic step(input int n);
    repeat (n) begin
      @(negedge clk);
      compare_model();
      if (prev_clk && !dac_clk) seen.push_back(dac_data);
      prev_clk = dac_clk;
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push_one(input logic [DW-1:0] d);
    bit done;
    done = 1'b0;
    s_data  = d;
    s_valid = 1'b1;
    for (int i = 0; i < 200 && !done; i++) begin
      done = s_ready;
      step(1);
    end
    s_valid = 1'b0;
    if (!done) timeout_fail("push_accept");
  endtask

  task automatic wait_uf(input string name);
    bit hit;
    hit = 1'b0;
    for (int i = 0; i < 80 && !hit; i++) begin
      if (underflow) hit = 1'b1;
      else step(1);
    end
    if (!hit) timeout_fail(name);
  endtask

  task automatic wait_data(input string name, input logic [DW-1:0] v);
    bit hit;
    hit = 1'b0;
    for (int i = 0; i < 60 && !hit; i++) begin
      if (dac_data == v) hit = 1'b1;
      else step(1);
    end
    if (!hit) timeout_fail(name);
  endtask

  task automatic check_seq(input string name, input int from,
                           input logic [DW-1:0] a, input logic [DW-1:0] b,
                           input logic [DW-1:0] c, input logic [DW-1:0] d);
    int i0;
    i0 = -1;
    for (int k = from; k < seen.size(); k++) if (i0 < 0 && seen[k] == a) i0 = k;
    if (i0 < 0 || seen.size() < i0 + 4) begin
      timeout_fail(name);
    end else begin
      chk({name, "_1"}, {20'd0, seen[i0+1]}, {20'd0, b});
      chk({name, "_2"}, {20'd0, seen[i0+2]}, {20'd0, c});
      chk({name, "_3"}, {20'd0, seen[i0+3]}, {20'd0, d});
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int mark;
    int acc;
    bit hit;

    // Reset state with enable low
    step(3);
    chk("rst_dac_clk", {31'd0, dac_clk}, 0);
    chk("rst_dac_data", {20'd0, dac_data}, 32'h800);
    chk("rst_s_ready", {31'd0, s_ready}, 0);
    chk("rst_level", {28'd0, fifo_level}, 0);
    reset = 1'b1;
    step(1);
    chk("ready_after_release", {31'd0, s_ready}, 1);
    step(4);
    chk("idle_dac_clk", {31'd0, dac_clk}, 0);

    // Prime, order and underflow counting
    mark = seen.size();
    twos_comp = 1'b0;
    enable = 1'b1;
    push_one(12'h001); push_one(12'h002); push_one(12'h003); push_one(12'h004);
    wait_uf("first_underflow");
    check_seq("order", mark, 12'h001, 12'h002, 12'h003, 12'h004);
    chk("uf_count_1", {16'd0, underflow_count}, 1);
    chk("uf_hold_data", {20'd0, dac_data}, 32'h004);
    step(4);
    chk("uf_count_3", {16'd0, underflow_count}, 3);
    chk("uf_pulse", {31'd0, underflow}, 1);

    // Disable with empty FIFO
    enable = 1'b0;
    step(6);
    chk("dis_dac_clk", {31'd0, dac_clk}, 0);
    chk("dis_dac_data", {20'd0, dac_data}, 32'h800);

    // Backpressure: 9 offered, 8 accepted
    acc = 0;
    for (int i = 0; i < 9; i++) begin
      s_data  = 12'h100 + 12'(i);
      s_valid = 1'b1;
      if (s_ready) acc++;
      step(1);
    end
    s_valid = 1'b0;
    chk("bp_accepted", acc, 8);
    chk("bp_level", {28'd0, fifo_level}, 8);
    chk("bp_ready", {31'd0, s_ready}, 0);
    mark = seen.size();
    enable = 1'b1;
    hit = 1'b0;
    for (int i = 0; i < 20 && !hit; i++) begin
      if (s_ready) hit = 1'b1;
      else step(1);
    end
    if (!hit) timeout_fail("ready_after_pop");
    chk("level_after_pop", {28'd0, fifo_level}, 7);

    // Drop enable mid-run: samples retained
    wait_data("reach_102", 12'h102);
    enable = 1'b0;
    step(6);
    chk("stop_level", {28'd0, fifo_level}, 5);
    chk("stop_dac_clk", {31'd0, dac_clk}, 0);
    chk("stop_dac_data", {20'd0, dac_data}, 32'h800);
    chk("stop_seq0", {20'd0, seen[mark]}, 32'h100);
    chk("stop_seq1", {20'd0, seen[mark+1]}, 32'h101);
    chk("stop_seq2", {20'd0, seen[mark+2]}, 32'h102);

    // Reset asserted mid-run acts before the next clock edge
    enable = 1'b1;
    wait_data("reach_104", 12'h104);
    step(1);
    chk("pre_rst_dac_clk", {31'd0, dac_clk}, 1);
    #2;
    reset = 1'b0;
    ucnt_base = 0;
    uev_mark = 0;
    #1;
    chk("arst_dac_clk", {31'd0, dac_clk}, 0);
    chk("arst_dac_data", {20'd0, dac_data}, 32'h800);
    chk("arst_s_ready", {31'd0, s_ready}, 0);
    chk("arst_underflow", {31'd0, underflow}, 0);
    chk("arst_count", {16'd0, underflow_count}, 0);
    chk("arst_level", {28'd0, fifo_level}, 0);
    step(2);
    enable = 1'b0;
    reset = 1'b1;
    step(2);

    // Two's complement conversion
    mark = seen.size();
    twos_comp = 1'b1;
    enable = 1'b1;
    push_one(12'h7FF); push_one(12'h800); push_one(12'h000); push_one(12'hFFF);
    wait_uf("fmt_underflow");
    check_seq("fmt", mark, 12'hFFF, 12'h000, 12'h800, 12'h7FF);
    chk("fmt_count", {16'd0, underflow_count}, 1);

    // Saturation of the underflow counter
    ucnt_base = 16'hFFFE;
    uev_mark  = m_uevents;
    force dut.ucnt_q = 16'hFFFE;
    #1;
    release dut.ucnt_q;
    step(4);
    chk("sat_count", {16'd0, underflow_count}, 32'hFFFF);
    step(4);
    chk("sat_hold", {16'd0, underflow_count}, 32'hFFFF);
    chk("sat_pulse", {31'd0, underflow}, 1);

    enable = 1'b0;
    step(6);
    chk("end_dac_clk", {31'd0, dac_clk}, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
